// File: rtl/nn_avalon_mem_responder.sv
// Avalon-MM 16-bit memory responder: programmable wait states, fixed-latency pipelined reads,
// byte-enabled writes and a host backdoor port for preload/readback.
module nn_avalon_mem_responder #(
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter int unsigned DEPTH_LOG2   = 12,
  parameter int unsigned WAIT_STATES  = 2,
  parameter int unsigned READ_LATENCY = 3,
  parameter logic [15:0] ERR_DATA     = 16'hDEAD
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_chipselect,
  input  logic                  i_read_n,
  input  logic                  i_write_n,
  input  logic [31:0]           i_address,
  input  logic [1:0]            i_byteenable,
  input  logic [15:0]           i_writedata,
  output logic                  o_waitrequest,
  output logic                  o_readdatavalid,
  output logic [15:0]           o_readdata,
  input  logic                  i_hld_we,
  input  logic [DEPTH_LOG2-1:0] i_hld_addr,
  input  logic [15:0]           i_hld_wdata,
  output logic [15:0]           o_hld_rdata,
  output logic [15:0]           o_rd_count,
  output logic [15:0]           o_wr_count,
  output logic                  o_err_addr,
  output logic                  o_err_proto
);

  localparam int unsigned Words = 2 ** DEPTH_LOG2;
  localparam int unsigned WcntW = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
  localparam logic [WcntW-1:0] WcntMax = WcntW'(WAIT_STATES);

  logic [15:0]             r_mem [Words];
  logic [WcntW-1:0]        r_wcnt;
  logic [READ_LATENCY-1:0] r_pv;
  logic [15:0]             r_pd [READ_LATENCY];
  logic [15:0]             r_hld_rdata;
  logic [15:0]             r_rd_count;
  logic [15:0]             r_wr_count;
  logic                    r_err_addr;
  logic                    r_err_proto;

  logic                    w_req;
  logic                    w_wait;
  logic                    w_accept;
  logic                    w_wr_acc;
  logic                    w_rd_acc;
  logic                    w_valid;
  logic [31:0]             w_off;
  logic [DEPTH_LOG2-1:0]   w_idx;
  logic [15:0]             w_rd_word;
  logic                    w_host_wr;

  // Both strobes low counts as a write (flagged separately).
  assign w_req    = i_chipselect & (~i_read_n | ~i_write_n);
  assign w_wait   = w_req & (r_wcnt != WcntMax);
  assign w_accept = w_req & ~w_wait;
  assign w_wr_acc = w_accept & ~i_write_n;
  assign w_rd_acc = w_accept & i_write_n;

  assign w_off     = i_address - BASE_ADDR;
  assign w_valid   = ~w_off[0] & (w_off[31:DEPTH_LOG2+1] == '0);
  assign w_idx     = w_off[DEPTH_LOG2:1];
  assign w_rd_word = w_valid ? r_mem[w_idx] : ERR_DATA;

  // Avalon write wins over a host write to the same word in the same cycle.
  assign w_host_wr = i_hld_we & ~(w_wr_acc & w_valid & (w_idx == i_hld_addr));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wcnt <= '0;
    end else if (!w_req || w_accept) begin
      r_wcnt <= '0;
    end else begin
      r_wcnt <= r_wcnt + 1'b1;
    end
  end

  // Memory is deliberately outside reset so preloaded contents survive it.
  always_ff @(posedge clk) begin
    if (w_host_wr) begin
      r_mem[i_hld_addr] <= i_hld_wdata;
    end
    if (w_wr_acc && w_valid) begin
      if (i_byteenable[0]) r_mem[w_idx][7:0]  <= i_writedata[7:0];
      if (i_byteenable[1]) r_mem[w_idx][15:8] <= i_writedata[15:8];
    end
  end

  // Data stages only load alongside a valid bit, so the last stage holds the last returned word.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pv <= '0;
      for (int i = 0; i < READ_LATENCY; i++) r_pd[i] <= '0;
    end else begin
      r_pv[0] <= w_rd_acc;
      if (w_rd_acc) r_pd[0] <= w_rd_word;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        if (r_pv[i-1]) r_pd[i] <= r_pd[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_hld_rdata <= '0;
      r_rd_count  <= '0;
      r_wr_count  <= '0;
      r_err_addr  <= 1'b0;
      r_err_proto <= 1'b0;
    end else begin
      r_hld_rdata <= r_mem[i_hld_addr];
      if (w_rd_acc && (r_rd_count != 16'hFFFF)) r_rd_count <= r_rd_count + 16'd1;
      if (w_wr_acc && (r_wr_count != 16'hFFFF)) r_wr_count <= r_wr_count + 16'd1;
      if (w_accept && !w_valid) r_err_addr <= 1'b1;
      if (w_accept && !i_read_n && !i_write_n) r_err_proto <= 1'b1;
    end
  end

  assign o_waitrequest   = w_wait;
  assign o_readdatavalid = r_pv[READ_LATENCY-1];
  assign o_readdata      = r_pd[READ_LATENCY-1];
  assign o_hld_rdata     = r_hld_rdata;
  assign o_rd_count      = r_rd_count;
  assign o_wr_count      = r_wr_count;
  assign o_err_addr      = r_err_addr;
  assign o_err_proto     = r_err_proto;

endmodule

// File: tb/tb_nn_avalon_mem_responder.sv
// Bench for nn_avalon_mem_responder: directed vectors on a 2-wait-state instance, random
// traffic against a queue/array reference model on a zero-wait-state instance.
module tb_nn_avalon_mem_responder;

  localparam logic [31:0] BBase   = 32'h0000_1000;
  localparam logic [15:0] ErrData = 16'hDEAD;

  typedef struct {
    int          c;
    logic [15:0] d;
  } ev_t;

  typedef struct {
    logic [15:0] pre;
    int          idx;
    logic [31:0] addr;
    logic [1:0]  be;
    logic [15:0] wd;
    logic [15:0] exp_mem;
    logic [15:0] exp_rd;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_cs, a_rn, a_wn, a_wr, a_rdv, a_hwe, a_ea, a_ep;
  logic [31:0] a_addr;
  logic [1:0]  a_be;
  logic [15:0] a_wd, a_rd, a_hwd, a_hrd, a_rc, a_wc;
  logic [11:0] a_haddr;

  logic        b_cs, b_rn, b_wn, b_wr, b_rdv, b_hwe, b_ea, b_ep;
  logic [31:0] b_addr;
  logic [1:0]  b_be;
  logic [15:0] b_wd, b_rd, b_hwd, b_hrd, b_rc, b_wc;
  logic [11:0] b_haddr;

  nn_avalon_mem_responder #(
    .BASE_ADDR(32'h0), .DEPTH_LOG2(12), .WAIT_STATES(2), .READ_LATENCY(3), .ERR_DATA(ErrData)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .i_chipselect(a_cs), .i_read_n(a_rn), .i_write_n(a_wn),
    .i_address(a_addr), .i_byteenable(a_be), .i_writedata(a_wd), .o_waitrequest(a_wr),
    .o_readdatavalid(a_rdv), .o_readdata(a_rd), .i_hld_we(a_hwe), .i_hld_addr(a_haddr),
    .i_hld_wdata(a_hwd), .o_hld_rdata(a_hrd), .o_rd_count(a_rc), .o_wr_count(a_wc),
    .o_err_addr(a_ea), .o_err_proto(a_ep)
  );

  nn_avalon_mem_responder #(
    .BASE_ADDR(BBase), .DEPTH_LOG2(12), .WAIT_STATES(0), .READ_LATENCY(3), .ERR_DATA(ErrData)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .i_chipselect(b_cs), .i_read_n(b_rn), .i_write_n(b_wn),
    .i_address(b_addr), .i_byteenable(b_be), .i_writedata(b_wd), .o_waitrequest(b_wr),
    .o_readdatavalid(b_rdv), .o_readdata(b_rd), .i_hld_we(b_hwe), .i_hld_addr(b_haddr),
    .i_hld_wdata(b_hwd), .o_hld_rdata(b_hrd), .o_rd_count(b_rc), .o_wr_count(b_wc),
    .o_err_addr(b_ea), .o_err_proto(b_ep)
  );

  ev_t a_q[$];
  ev_t b_q[$];
  bit  b_mon = 1'b0;

  always @(negedge clk) begin
    if (a_rdv) a_q.push_back('{cyc, a_rd});
    if (b_mon && b_rdv) b_q.push_back('{cyc, b_rd});
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_host_wr(input int idx, input logic [15:0] d);
    a_hwe = 1'b1; a_haddr = 12'(idx); a_hwd = d;
    step();
    a_hwe = 1'b0;
  endtask

  task automatic a_host_rd(input int idx, output logic [15:0] d);
    a_haddr = 12'(idx);
    step();
    d = a_hrd;
  endtask

  task automatic b_host_wr(input int idx, input logic [15:0] d);
    b_hwe = 1'b1; b_haddr = 12'(idx); b_hwd = d;
    step();
    b_hwe = 1'b0;
  endtask

  // Holds the request until accepted; returns the accept cycle and count of stalled cycles.
  task automatic a_access(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [1:0] be, input logic [15:0] wd,
                          output int acc, output int waits);
    a_cs = 1'b1; a_rn = ~rd; a_wn = ~wr; a_addr = addr; a_be = be; a_wd = wd;
    acc = -1;
    waits = 0;
    for (int i = 0; i < 20 && acc < 0; i++) begin
      #1;
      if (a_wr) waits++;
      else acc = cyc;
      step();
    end
    a_cs = 1'b0; a_rn = 1'b1; a_wn = 1'b1;
    chk("accept within bound", 32'(acc >= 0), 32'd1);
  endtask

  task automatic a_read_chk(input string name, input logic [31:0] addr, input logic [15:0] exp);
    int acc, waits;
    a_q.delete();
    a_access(1'b1, 1'b0, addr, 2'b11, 16'h0, acc, waits);
    chk({name, " waits"}, 32'(waits), 32'd2);
    while (cyc < acc + 5) step();
    chk({name, " rdv count"}, 32'(a_q.size()), 32'd1);
    if (a_q.size() > 0) begin
      chk({name, " latency"}, 32'(a_q[0].c - acc), 32'd3);
      chk({name, " data"}, 32'(a_q[0].d), 32'(exp));
    end
  endtask

  vec_t        tbl [6];
  logic [15:0] mdl [4096];
  ev_t         exp_q[$];

  initial begin
    int          acc, waits, acc0, op, sel, widx, m_rc, m_wc;
    bit          m_ea, m_ep, req, valid, host_ok;
    logic [31:0] off;
    logic [15:0] got, exp_h, last_rd;

    tbl[0] = '{16'h5555, 2,    32'h0000_0004, 2'b01, 16'hABCD, 16'h55CD, 16'h55CD};
    tbl[1] = '{16'h5555, 3,    32'h0000_0006, 2'b10, 16'hABCD, 16'hAB55, 16'hAB55};
    tbl[2] = '{16'h1111, 7,    32'h0000_000E, 2'b11, 16'hBEEF, 16'hBEEF, 16'hBEEF};
    tbl[3] = '{16'h2222, 8,    32'h0000_0010, 2'b00, 16'hFFFF, 16'h2222, 16'h2222};
    tbl[4] = '{16'h3333, 4095, 32'h0000_1FFE, 2'b11, 16'h7777, 16'h7777, 16'h7777};
    tbl[5] = '{16'h4444, 9,    32'h0000_0013, 2'b11, 16'h9999, 16'h4444, ErrData};

    a_cs = 0; a_rn = 1; a_wn = 1; a_addr = 0; a_be = 0; a_wd = 0; a_hwe = 0; a_haddr = 0;
    a_hwd = 0;
    b_cs = 0; b_rn = 1; b_wn = 1; b_addr = 0; b_be = 0; b_wd = 0; b_hwe = 0; b_haddr = 0;
    b_hwd = 0;
    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;

    // Reset state
    chk("reset rdv", 32'(a_rdv), 32'd0);
    chk("reset readdata", 32'(a_rd), 32'd0);
    chk("reset hld_rdata", 32'(a_hrd), 32'd0);
    chk("reset rd_count", 32'(a_rc), 32'd0);
    chk("reset wr_count", 32'(a_wc), 32'd0);
    chk("reset err_addr", 32'(a_ea), 32'd0);
    chk("reset err_proto", 32'(a_ep), 32'd0);
    chk("idle waitrequest", 32'(a_wr), 32'd0);

    // Wait states and read latency
    a_host_wr(5, 16'h1234);
    a_read_chk("read 0xA", 32'h0000_000A, 16'h1234);
    chk("rd_count after 1 read", 32'(a_rc), 32'd1);

    // Invalid reads and sticky err_addr
    chk("err_addr before bad read", 32'(a_ea), 32'd0);
    a_read_chk("odd read", 32'h0000_0003, ErrData);
    chk("err_addr after odd read", 32'(a_ea), 32'd1);
    a_read_chk("range read", 32'h0000_2000, ErrData);
    a_read_chk("valid read after err", 32'h0000_000A, 16'h1234);
    chk("err_addr sticky", 32'(a_ea), 32'd1);

    // Byte-enabled writes, table driven
    for (int i = 0; i < 6; i++) begin
      a_host_wr(tbl[i].idx, tbl[i].pre);
      a_access(1'b0, 1'b1, tbl[i].addr, tbl[i].be, tbl[i].wd, acc, waits);
      if (i == 0) chk("wr_count after 1 write", 32'(a_wc), 32'd1);
      a_host_rd(tbl[i].idx, got);
      chk($sformatf("vec%0d mem", i), 32'(got), 32'(tbl[i].exp_mem));
      a_read_chk($sformatf("vec%0d read", i), tbl[i].addr, tbl[i].exp_rd);
    end

    // Both strobes low: treated as a write, protocol error flagged
    chk("err_proto before", 32'(a_ep), 32'd0);
    a_q.delete();
    a_access(1'b1, 1'b1, 32'h0, 2'b11, 16'h0F0F, acc, waits);
    while (cyc < acc + 6) step();
    chk("proto no rdv", 32'(a_q.size()), 32'd0);
    a_host_rd(0, got);
    chk("proto mem[0]", 32'(got), 32'h0F0F);
    chk("err_proto set", 32'(a_ep), 32'd1);
    chk("rd_count total", 32'(a_rc), 32'd10);
    chk("wr_count total", 32'(a_wc), 32'd7);

    // Back-to-back reads with zero wait states
    for (int j = 0; j < 4; j++) b_host_wr(10 + j, 16'hC000 + 16'(j));
    b_mon = 1'b1;
    b_q.delete();
    acc0 = 0;
    for (int j = 0; j < 4; j++) begin
      b_cs = 1'b1; b_rn = 1'b0; b_wn = 1'b1; b_addr = BBase + 32'(2 * (10 + j));
      #1;
      chk("b2b waitrequest", 32'(b_wr), 32'd0);
      if (j == 0) acc0 = cyc;
      step();
    end
    b_cs = 1'b0; b_rn = 1'b1;
    while (cyc < acc0 + 9) step();
    chk("b2b rdv count", 32'(b_q.size()), 32'd4);
    for (int j = 0; j < 4 && j < b_q.size(); j++) begin
      chk($sformatf("b2b%0d cycle", j), 32'(b_q[j].c - acc0), 32'(3 + j));
      chk($sformatf("b2b%0d data", j), 32'(b_q[j].d), 32'(16'hC000 + 16'(j)));
    end
    b_mon = 1'b0;

    // Random traffic against the reference model
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    m_rc = 0; m_wc = 0; m_ea = 0; m_ep = 0; last_rd = '0;
    for (int i = 0; i < 32; i++) begin
      got = 16'($urandom);
      mdl[i] = got;
      b_host_wr(i, got);
    end
    for (int k = 0; k < 405; k++) begin
      b_cs = ($urandom_range(0, 9) != 0);
      op = $urandom_range(0, 7);
      b_rn = !(op <= 2 || op == 6);
      b_wn = !(op >= 3 && op <= 6);
      widx = $urandom_range(0, 31);
      sel = $urandom_range(0, 9);
      if (sel <= 6)      b_addr = BBase + 32'(2 * widx);
      else if (sel == 7) b_addr = BBase + 32'(2 * widx + 1);
      else if (sel == 8) b_addr = BBase + 32'h2000 + 32'(2 * widx);
      else               b_addr = BBase - 32'd2 - 32'(2 * widx);
      b_be = 2'($urandom);
      b_wd = 16'($urandom);
      b_hwe = ($urandom_range(0, 2) == 0);
      b_haddr = 12'($urandom_range(0, 31));
      b_hwd = 16'($urandom);
      if (k >= 400) begin
        b_cs = 1'b0; b_hwe = 1'b0;
      end
      #1;
      chk("rand waitrequest", 32'(b_wr), 32'd0);
      req = b_cs && (!b_rn || !b_wn);
      off = b_addr - BBase;
      valid = (off % 2 == 0) && (off / 2 < 4096);
      widx = int'((off / 2) % 4096);
      exp_h = mdl[b_haddr];
      host_ok = b_hwe;
      if (req) begin
        if (!b_wn) begin
          if (m_wc < 65535) m_wc++;
          if (!valid) m_ea = 1;
          if (!b_rn) m_ep = 1;
          if (valid && (int'(b_haddr) == widx)) host_ok = 0;
        end else begin
          if (m_rc < 65535) m_rc++;
          if (!valid) m_ea = 1;
          exp_q.push_back('{cyc + 3, valid ? mdl[widx] : ErrData});
        end
      end
      if (host_ok) mdl[b_haddr] = b_hwd;
      if (req && !b_wn && valid) begin
        if (b_be[0]) mdl[widx][7:0] = b_wd[7:0];
        if (b_be[1]) mdl[widx][15:8] = b_wd[15:8];
      end
      step();
      chk("rand hld_rdata", 32'(b_hrd), 32'(exp_h));
      if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
        chk("rand rdv", 32'(b_rdv), 32'd1);
        chk("rand readdata", 32'(b_rd), 32'(exp_q[0].d));
        last_rd = exp_q[0].d;
        void'(exp_q.pop_front());
      end else begin
        chk("rand rdv idle", 32'(b_rdv), 32'd0);
        chk("rand readdata hold", 32'(b_rd), 32'(last_rd));
      end
    end
    chk("rand pending reads", 32'(exp_q.size()), 32'd0);
    chk("rand rd_count", 32'(b_rc), 32'(m_rc));
    chk("rand wr_count", 32'(b_wc), 32'(m_wc));
    chk("rand err_addr", 32'(b_ea), 32'(m_ea));
    chk("rand err_proto", 32'(b_ep), 32'(m_ep));

    // Read counter saturation
    b_cs = 1'b1; b_rn = 1'b0; b_wn = 1'b1; b_addr = BBase;
    repeat (65540) step();
    b_cs = 1'b0; b_rn = 1'b1;
    step();
    chk("rd_count saturates", 32'(b_rc), 32'hFFFF);
    chk("wr_count unchanged", 32'(b_wc), 32'(m_wc));

    // Reset with a read in flight
    a_q.delete();
    a_access(1'b1, 1'b0, 32'h0000_000A, 2'b11, 16'h0, acc, waits);
    reset_n = 1'b0;
    step();
    chk("inflight reset rdv", 32'(a_rdv), 32'd0);
    chk("inflight reset readdata", 32'(a_rd), 32'd0);
    chk("inflight reset hld_rdata", 32'(a_hrd), 32'd0);
    reset_n = 1'b1;
    while (cyc < acc + 8) step();
    chk("flushed read never returns", 32'(a_q.size()), 32'd0);
    chk("post reset rd_count", 32'(a_rc), 32'd0);
    chk("post reset wr_count", 32'(a_wc), 32'd0);
    chk("post reset err_addr", 32'(a_ea), 32'd0);
    chk("post reset err_proto", 32'(a_ep), 32'd0);
    a_host_rd(5, got);
    chk("memory survives reset", 32'(got), 32'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
